// File: rtl/mips_debug_unit.sv
// mips_debug_unit: UART-driven loader, run/step controller and PC/data reporter for the MIPS pipeline
module mips_debug_unit #(
  parameter int NB_BITS = 32,
  parameter int NB_ADDR = 7,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_mips_clk_en,
  output logic               o_mips_rst,
  output logic               o_imem_we,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_BITS-1:0] o_imem_data,
  input  logic [NB_BITS-1:0] i_mips_pc,
  input  logic [NB_BITS-1:0] i_mips_data,
  input  logic               i_halt
);
  localparam int WPB = NB_BITS / NB_BYTE;
  typedef enum logic [2:0] {IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, STEP, RUN, SEND, WAIT_TX} state_t;
  state_t state, state_n;
  logic               rst_q;
  logic [NB_BYTE:0]   cnt;
  logic [NB_ADDR-1:0] addr;
  logic [NB_BITS-1:0] sh;
  logic [1:0]         bidx;
  logic [2:0]         tidx;
  logic [2*NB_BITS-1:0] rep;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (i_rx_valid)
                   state_n = i_rx_data == 8'h4C ? LOAD_CNT :
                             i_rx_data == 8'h53 ? STEP :
                             i_rx_data == 8'h52 ? (i_halt ? SEND : RUN) : IDLE;
      LOAD_CNT:  if (i_rx_valid) state_n = LOAD_BYTE;
      LOAD_BYTE: if (i_rx_valid && bidx == 2'(WPB-1)) state_n = LOAD_WR;
      LOAD_WR:   state_n = cnt == 1 ? IDLE : LOAD_BYTE;
      STEP:      state_n = SEND;
      RUN:       if (i_halt) state_n = SEND;
      SEND:      state_n = WAIT_TX;
      WAIT_TX:   if (i_tx_done) state_n = tidx == 3'(2*WPB-1) ? IDLE : SEND;
      default:   state_n = IDLE;
    endcase
  end
  assign o_mips_clk_en = state == STEP || state == RUN;
  assign o_imem_we     = state == LOAD_WR;
  assign o_tx_start    = state == SEND;
  assign o_mips_rst    = rst_q || state inside {LOAD_CNT, LOAD_BYTE, LOAD_WR};
  assign o_imem_addr   = addr;
  assign o_imem_data   = sh;
  assign o_tx_data     = rep[2*NB_BITS-1 -: NB_BYTE];
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      rst_q <= 1'b1;
      cnt   <= '0;
      addr  <= '0;
      sh    <= '0;
      bidx  <= '0;
      tidx  <= '0;
      rep   <= '0;
    end else begin
      state <= state_n;
      rst_q <= 1'b0;
      if (state == LOAD_CNT && i_rx_valid) begin
        cnt  <= {i_rx_data == 0, i_rx_data};
        addr <= '0;
        bidx <= '0;
      end
      if (state == LOAD_BYTE && i_rx_valid) begin
        sh   <= {sh[NB_BITS-NB_BYTE-1:0], i_rx_data};
        bidx <= bidx + 1'b1;
      end
      if (state == LOAD_WR) begin
        addr <= addr + 1'b1;
        cnt  <= cnt - 1'b1;
      end
      // snapshot PC/data once per report; the report then shifts out MSB first
      if (state_n == SEND && state != WAIT_TX) begin
        rep  <= {i_mips_pc, i_mips_data};
        tidx <= '0;
      end
      if (state == WAIT_TX && i_tx_done) begin
        rep  <= rep << NB_BYTE;
        tidx <= tidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mips_debug_unit.sv
// tb_mips_debug_unit: scoreboard bench for load, step, run, reporting, ignored bytes and reset abort
module tb_mips_debug_unit;
  logic        clk = 0, rst = 1;
  logic [7:0]  i_rx_data = 0;
  logic        i_rx_valid = 0, i_tx_done = 0, i_halt = 0;
  logic [31:0] i_mips_pc = 0, i_mips_data = 0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start, o_mips_clk_en, o_mips_rst, o_imem_we;
  logic [6:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  int checks = 0, errors = 0;
  int en_cnt = 0, wr_cnt = 0, tx_cnt = 0;
  logic [6:0] last_addr = 0;
  bit busy = 0;
  logic [7:0]  tx_q[$];
  logic [38:0] wr_q[$];

  mips_debug_unit dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_mips_clk_en(o_mips_clk_en), .o_mips_rst(o_mips_rst), .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .i_mips_pc(i_mips_pc), .i_mips_data(i_mips_data), .i_halt(i_halt));

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  always @(negedge clk) if (o_mips_clk_en) en_cnt++;

  always @(negedge clk) if (o_imem_we) begin
    logic [38:0] e;
    wr_cnt++;
    last_addr = o_imem_addr;
    checks++;
    if (wr_q.size() == 0) begin
      errors++;
      $display("FAIL imem_extra addr=%0d data=%h required none", o_imem_addr, o_imem_data);
    end else begin
      e = wr_q.pop_front();
      if ({o_imem_addr, o_imem_data} !== e) begin
        errors++;
        $display("FAIL imem_write got %0d:%h required %0d:%h", o_imem_addr, o_imem_data, e[38:32], e[31:0]);
      end
    end
    checks++;
    if (o_mips_rst !== 1'b1) begin
      errors++;
      $display("FAIL rst_during_write got %b required 1", o_mips_rst);
    end
  end

  // TX model: a bogus done in the start cycle, then the real done a few cycles later
  initial forever begin
    @(negedge clk);
    while (o_tx_start) begin
      busy = 1;
      tx_cnt++;
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_extra got %h required none", o_tx_data);
      end else begin
        logic [7:0] e;
        e = tx_q.pop_front();
        if (o_tx_data !== e) begin
          errors++;
          $display("FAIL tx_byte got %h required %h", o_tx_data, e);
        end
      end
      i_tx_done = 1;
      @(negedge clk);
      i_tx_done = 0;
      repeat (2) @(negedge clk);
      i_tx_done = 1;
      @(negedge clk);
      i_tx_done = 0;
      busy = 0;
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    i_rx_data = b;
    i_rx_valid = 1;
    @(negedge clk);
    i_rx_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_rx(w[31-8*i -: 8]);
      checks++;
      if (o_mips_rst !== 1'b1) begin
        errors++;
        $display("FAIL rst_in_load got %b required 1", o_mips_rst);
      end
    end
  endtask

  task automatic push_report(input logic [31:0] pc, input logic [31:0] d);
    logic [63:0] r;
    r = {pc, d};
    for (int i = 0; i < 8; i++) tx_q.push_back(r[63-8*i -: 8]);
  endtask

  task automatic wait_report(input string name);
    int c;
    for (c = 0; c < 400 && (tx_q.size() != 0 || busy); c++) @(negedge clk);
    checks++;
    if (tx_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required 0", name, tx_q.size());
    end
    checks++;
    if (tx_cnt !== 8) begin
      errors++;
      $display("FAIL %s_tx_count got %0d required 8", name, tx_cnt);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_mips_rst !== 1 || o_mips_clk_en !== 0 || o_tx_start !== 0 || o_imem_we !== 0) begin
      errors++;
      $display("FAIL reset_ctrl got rst=%b en=%b start=%b we=%b required 1 0 0 0", o_mips_rst, o_mips_clk_en, o_tx_start, o_imem_we);
    end
    checks++;
    if (o_tx_data !== 0 || o_imem_addr !== 0 || o_imem_data !== 0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h required 0 0 0", o_tx_data, o_imem_addr, o_imem_data);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_mips_rst !== 0) begin
      errors++;
      $display("FAIL reset_release got %b required 0", o_mips_rst);
    end
  endtask

  task automatic test_load;
    wr_cnt = 0;
    wr_q.push_back({7'd0, 32'h00000020});
    wr_q.push_back({7'd1, 32'hAABBCCDD});
    send_rx(8'h4C);
    send_rx(8'h02);
    send_word(32'h00000020);
    send_word(32'hAABBCCDD);
    @(negedge clk);
    checks++;
    if (o_mips_rst !== 0 || wr_cnt !== 2 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL load_done got rst=%b writes=%0d required 0 2", o_mips_rst, wr_cnt);
    end
  endtask

  task automatic test_step;
    i_mips_pc = 32'h4; i_mips_data = 32'h7;
    en_cnt = 0; tx_cnt = 0;
    push_report(32'h4, 32'h7);
    send_rx(8'h53);
    wait_report("step");
    checks++;
    if (en_cnt !== 1) begin
      errors++;
      $display("FAIL step_en got %0d required 1", en_cnt);
    end
  endtask

  task automatic test_run;
    i_mips_pc = 32'h12345678; i_mips_data = 32'hDEADBEEF;
    en_cnt = 0; tx_cnt = 0;
    push_report(32'h12345678, 32'hDEADBEEF);
    send_rx(8'h52);
    repeat (9) @(negedge clk);
    i_halt = 1;
    @(negedge clk);
    i_halt = 0;
    wait_report("run");
    checks++;
    if (en_cnt !== 10) begin
      errors++;
      $display("FAIL run_en got %0d required 10", en_cnt);
    end
    i_mips_pc = 32'h00000040; i_mips_data = 32'h0000ABCD;
    tx_cnt = 0;
    push_report(32'h40, 32'hABCD);
    send_rx(8'h53);
    wait_report("after_run");
    checks++;
    if (en_cnt !== 11) begin
      errors++;
      $display("FAIL after_run_en got %0d required 11", en_cnt);
    end
  endtask

  task automatic test_halt_idle;
    i_mips_pc = 32'hCAFEF00D; i_mips_data = 32'h01020304;
    en_cnt = 0; tx_cnt = 0;
    i_halt = 1;
    push_report(32'hCAFEF00D, 32'h01020304);
    send_rx(8'h52);
    i_halt = 0;
    wait_report("halt_idle");
    checks++;
    if (en_cnt !== 0) begin
      errors++;
      $display("FAIL halt_idle_en got %0d required 0", en_cnt);
    end
  endtask

  task automatic test_ignore;
    en_cnt = 0; tx_cnt = 0; wr_cnt = 0;
    send_rx(8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (en_cnt !== 0 || tx_cnt !== 0 || wr_cnt !== 0 || o_mips_rst !== 0) begin
      errors++;
      $display("FAIL ignore_byte got en=%0d tx=%0d wr=%0d rst=%b required 0 0 0 0", en_cnt, tx_cnt, wr_cnt, o_mips_rst);
    end
    i_mips_pc = 32'h00000008; i_mips_data = 32'hFFFF0000;
    push_report(32'h8, 32'hFFFF0000);
    send_rx(8'h53);
    repeat (3) @(negedge clk);
    send_rx(8'h53);
    wait_report("ignore_send");
    checks++;
    if (en_cnt !== 1) begin
      errors++;
      $display("FAIL ignore_send_en got %0d required 1", en_cnt);
    end
  endtask

  task automatic test_abort;
    wr_cnt = 0;
    send_rx(8'h4C);
    send_rx(8'h01);
    send_rx(8'h11);
    send_rx(8'h22);
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt !== 0 || o_mips_rst !== 1) begin
      errors++;
      $display("FAIL abort got writes=%0d rst=%b required 0 1", wr_cnt, o_mips_rst);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    wr_q.push_back({7'd0, 32'h11223344});
    send_rx(8'h4C);
    send_rx(8'h01);
    send_word(32'h11223344);
    @(negedge clk);
    checks++;
    if (wr_cnt !== 1 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL abort_reload got writes=%0d required 1", wr_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] w;
    wr_cnt = 0;
    send_rx(8'h4C);
    send_rx(8'h00);
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'h3C};
      wr_q.push_back({7'(i % 128), w});
      send_word(w);
    end
    @(negedge clk);
    checks++;
    if (wr_cnt !== 256 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_count got %0d required 256", wr_cnt);
    end
    checks++;
    if (last_addr !== 7'd127 || o_mips_rst !== 0) begin
      errors++;
      $display("FAIL wrap_last got addr=%0d rst=%b required 127 0", last_addr, o_mips_rst);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_step;
    test_run;
    test_halt_idle;
    test_ignore;
    test_abort;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
